// File: rtl/load_store_unit.sv
// load_store_unit: turns RISC-V byte/half/word loads and stores into whole-word
// memory accesses, with read-modify-write for sub-word stores and early rejection
// of misaligned, illegal-size or out-of-range requests.
// Latency after acceptance: error 1 cycle, load 2, word store 2, sub-word store 3.
// Backpressure: a single request in flight; req_ready only in IDLE, and the
// response is held stable until resp_ready.
// Ports:
//   clk/resetn        : clock, async active-low reset
//   req_*             : request channel from the core (valid/ready)
//   resp_*            : response channel to the core (valid/ready)
//   mem_*             : word-organised memory, combinational read, one-cycle write strobe
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;       // byte offset within the word; the rest of the address lives in mem_addr_q
  logic [31:0] wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic        accept;
  logic [1:0]  req_err;

  // Alignment/size faults take priority over the range check.
  always_comb begin
    req_err = 2'b00;
    if (req_size == 2'b11 ||
        (req_size == 2'b01 && req_addr[0]) ||
        (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
      req_err = 2'b01;
    end else if (req_addr >= ADDR_LIMIT) begin
      req_err = 2'b10;
    end
  end

  assign accept = req_valid && req_ready;

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] w;
    w = word;
    if (sz == 2'b00)      w[{off, 3'b000} +: 8]        = wd[7:0];
    else if (sz == 2'b01) w[{off[1], 4'b0000} +: 16]   = wd[15:0];
    else                  w = wd;
    return w;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return word;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err != 2'b00)                  state_d = S_RESP;
          else if (req_we && req_size == 2'b10)  state_d = S_WRITE;
          else                                   state_d = S_READ;
        end
      end
      S_READ:  state_d = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_we falls with the async reset of state_q.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    mem_we     = (state_q == S_WRITE);
    resp_valid = (state_q == S_RESP);
  end

  // Datapath. The word read in READ is folded straight into the registered
  // write word (stores) or the registered load result, so both are stable
  // for the whole WRITE / RESP cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 2'b00;
    end else begin
      if (accept) begin
        we_q       <= req_we;
        size_q     <= req_size;
        uns_q      <= req_unsigned;
        off_q      <= req_addr[1:0];
        wdata_q    <= req_wdata;
        mem_addr_q <= {req_addr[31:2], 2'b00};
        rdata_q    <= 32'h0;
        err_q      <= req_err;
        if (req_err == 2'b00 && req_we && req_size == 2'b10) mem_wdata_q <= req_wdata;
      end
      if (state_q == S_READ) begin
        if (we_q) mem_wdata_q <= merge_store(mem_rdata, wdata_q, size_q, off_q);
        else      rdata_q     <= extract_load(mem_rdata, size_q, off_q, uns_q);
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_LIMIT(32'h0000_1000)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we)
  );

  // Memory the DUT talks to, plus a bench-side preload port.
  logic [31:0] mem [0:1023];
  logic        tb_wr = 1'b0;
  logic [9:0]  tb_idx = 10'h0;
  logic [31:0] tb_dat = 32'h0;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[11:2]] <= mem_wdata;
    else if (tb_wr) mem[tb_idx] <= tb_dat;
  end

  // Reference model: byte-addressed memory image.
  logic [7:0] ref_mem [0:4095];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_rd;
  logic [1:0]  last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 2'd1;
    if (sz == 2'd1 && a % 2 != 0) return 2'd1;
    if (sz == 2'd2 && a % 4 != 0) return 2'd1;
    if (a >= 32'h1000) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] b;
    b = a - (a % 4);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[a+i]) << (8*i));
    if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // Issue one request, follow it to its response and check everything seen on the way.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    logic [1:0]  e;
    logic [31:0] er, exp_word, seen_a, seen_d;
    int lat, cyc, nwr, wcyc, wait_n, exp_nwr;
    e = model_err(sz, a);
    er = 32'h0;
    exp_word = 32'h0;
    if (e == 2'd0 && !we) er = model_load(sz, uns, a);
    if (e == 2'd0 && we) begin
      for (int i = 0; i < (1 << sz); i++) ref_mem[a+i] = wd[8*i +: 8];
      exp_word = ref_word(a);
    end
    lat = (e != 2'd0) ? 1 : ((we && sz != 2'd2) ? 3 : 2);
    exp_nwr = (e == 2'd0 && we) ? 1 : 0;
    last_rd = er;
    last_err = e;

    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    wait_n = 0;
    while (!req_ready && wait_n < 50) begin @(posedge clk); #1; wait_n++; end
    chk({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;

    cyc = 1; nwr = 0; wcyc = 0; seen_a = 32'h0; seen_d = 32'h0;
    while (cyc < 20) begin
      if (mem_we) begin nwr++; wcyc = cyc; seen_a = mem_addr; seen_d = mem_wdata; end
      if (resp_valid) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " resp_error"}, {30'b0, resp_error}, {30'b0, e});
    chk({tag, " resp_rdata"}, resp_rdata, er);
    chk({tag, " mem_we pulses"}, nwr, exp_nwr);
    if (exp_nwr == 1) begin
      chk({tag, " write cycle"}, wcyc, lat - 1);
      chk({tag, " write addr"}, seen_a, {a[31:2], 2'b00});
      chk({tag, " write data"}, seen_d, exp_word);
    end
    if (a < 32'h1000) chk({tag, " mem word"}, mem[a[11:2]], ref_word(a));
    if (resp_ready) begin
      @(posedge clk); #1;
      chk({tag, " resp_valid drop"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, " req_ready back"}, {31'b0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] orig, a;
    logic [1:0]  sz;
    int nwr, r;

    // Preload memory under reset.
    for (int i = 0; i < 1024; i++) begin
      tb_wr = 1'b1;
      tb_idx = 10'(i);
      tb_dat = (i == 4) ? 32'h80F1A2B3 : $urandom;
      for (int j = 0; j < 4; j++) ref_mem[4*i+j] = tb_dat[8*j +: 8];
      @(posedge clk); #1;
    end
    tb_wr = 1'b0;

    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_error", {30'b0, resp_error}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Sub-word loads and word load from 0x80F1A2B3.
    do_req("LB 0x10",  1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    do_req("LBU 0x13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_req("LH 0x12",  1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    do_req("LHU 0x12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    do_req("LW 0x10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Read-modify-write stores.
    do_req("SB 0x11", 1'b1, 2'd0, 1'b0, 32'h11, 32'hDEADBECC);
    chk("SB word", mem[4], 32'h80F1CCB3);
    do_req("SH 0x12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234);
    chk("SH word", mem[4], 32'h1234CCB3);

    // Alignment / size / range errors.
    do_req("SH 0x13",   1'b1, 2'd1, 1'b0, 32'h13, 32'h5555AAAA);
    do_req("LW 0x0E",   1'b0, 2'd2, 1'b0, 32'h0E, 32'h0);
    do_req("size3",     1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    do_req("LW 0x1000", 1'b0, 2'd2, 1'b0, 32'h00001000, 32'h0);
    do_req("SW top",    1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h12345678);
    do_req("LW 0xFFC",  1'b0, 2'd2, 1'b0, 32'h00000FFC, 32'h0);
    do_req("SW 0x40",   1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D);

    // Response backpressure with a second request waiting.
    resp_ready = 1'b0;
    do_req("bp LW", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
    req_addr = 32'h13; req_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp resp_rdata", resp_rdata, last_rd);
      chk("bp resp_error", {30'b0, resp_error}, {30'b0, last_err});
      chk("bp req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp handshake", {31'b0, resp_valid}, 32'd0);
    chk("bp ready after", {31'b0, req_ready}, 32'd1);
    do_req("bp LBU", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);

    // Reset while an SB sits in READ.
    orig = ref_word(32'h20);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h000000EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid-rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("mid-rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid-rst mem_addr", mem_addr, 32'h0);
    nwr = 0;
    for (int k = 0; k < 2; k++) begin @(posedge clk); #1; if (mem_we) nwr++; end
    resetn = 1'b1;
    chk("post-rst req_ready", {31'b0, req_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (mem_we) nwr++;
      if (resp_valid) nwr++;
    end
    chk("post-rst activity", nwr, 0);
    chk("post-rst word", mem[8], orig);
    do_req("post-rst LW", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    // Randomised traffic checked against the byte-level model.
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 19);
      sz = 2'($urandom_range(0, 3));
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) a = 32'hFFFFFF00 | $urandom_range(0, 255);
      else if (r < 5)  a = $urandom_range(0, 4095);
      else             a = $urandom_range(0, 127);
      if (r >= 8 && sz == 2'd1) a = a & ~32'h1;
      if (r >= 8 && sz == 2'd2) a = a & ~32'h3;
      do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core's execute/memory stage and the word-organised data memory. Converts RISC-V loads and stores (byte, halfword, word; signed/unsigned) into whole-word memory accesses. Extracts and sign/zero-extends load data. Performs read-modify-write for sub-word stores, and rejects misaligned or out-of-range requests without touching memory. Uses a valid/ready request channel and a valid/ready response channel toward the core.

Parameters:
ADDR_LIMIT, 32'h00001000, first illegal byte address (1024 words x 4 bytes); any address >= ADDR_LIMIT is rejected.

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load data (LBU/LHU); ignored for stores and words
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response available
resp_ready  in  1  core accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  2  00 ok, 01 misaligned/illegal size, 10 out of range
mem_addr  out  32  word-aligned byte address to memory (bits [1:0] always 0)
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data for mem_addr
mem_we  out  1  write strobe, single-cycle pulse

Behaviour:
- Reset (async, resetn=0):
  - state IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_error=0.
  - All latched request fields cleared.
- req_ready = (state==IDLE). Handshake occurs on the clk edge with req_valid&&req_ready.
  - The unit latches req_we, req_size, req_unsigned, req_addr and req_wdata.
  - It drives mem_addr = {req_addr[31:2],2'b00} from the following cycle.
- Error check at acceptance:
  - Checked in this order: size==11, half with addr[0]=1, or word with addr[1:0]!=0 -> error 01; otherwise addr>=ADDR_LIMIT -> error 10.
  - On error: next state RESP, no memory cycle, mem_we stays 0.
- States:
  - IDLE: wait for handshake. Next: RESP (error), READ (load or sub-word store), WRITE (word store).
  - READ: mem_we=0. The unit captures mem_rdata into rbuf at the end of the cycle. Next: RESP (load) or WRITE (store).
  - WRITE: mem_we=1 for exactly this one cycle. mem_addr and mem_wdata are stable for the whole cycle and held afterwards until the next accepted request. mem_wdata is formed as follows:
    - Word: req_wdata.
    - Byte: rbuf with byte lane addr[1:0] replaced by wdata[7:0].
    - Half: rbuf with lane addr[1] (bits 15:0 or 31:16) replaced by wdata[15:0].
    - Next: RESP.
  - RESP: resp_valid=1. resp_rdata and resp_error are registered and held stable until resp_valid&&resp_ready, then IDLE. New requests are not accepted while in RESP (req_ready=0).
- Load extraction:
  - Byte = rbuf[8*addr[1:0] +: 8].
  - Half = rbuf[16*addr[1] +: 16].
  - Sign-extend from the top bit unless req_unsigned.
  - Word = rbuf unchanged.
- Latency (request accepted at edge T, resp_valid visible after edge):
  - Error: T+1.
  - Load: T+2.
  - Word store: T+2.
  - Sub-word store: T+3.
  - With resp_ready held high, resp_valid lasts one cycle and req_ready returns the next cycle. Back-to-back throughput is therefore one request per latency+1 cycles.
- Reset mid-operation: any state returns immediately to IDLE. mem_we deasserts asynchronously. A partially completed store never produces a second write strobe after reset release.
- Only one mem_we pulse per store. Loads and errored requests never assert mem_we.

Test Plan:
1. Memory word at 0x10 = 0x80F1A2B3. Loads:
   - LB 0x10 -> 0xFFFFFFB3
   - LBU 0x13 -> 0x00000080
   - LH 0x12 -> 0xFFFF80F1
   - LHU 0x12 -> 0x000080F1
   - LW 0x10 -> 0x80F1A2B3
   - Each with resp_error=00, resp_valid at T+2 and mem_we never high.
2. SB addr 0x11, wdata 0xDEADBECC on word 0x80F1A2B3 -> exactly one mem_we pulse at T+2 with mem_addr=0x10 and mem_wdata=0x80F1CCB3; resp_valid at T+3, resp_rdata=0. A following SH 0x12 with wdata 0x1234 yields word 0x1234CCB3.
3. SH addr 0x13, LW addr 0x0E, and size=11 at 0x20 -> each gives resp_error=01 at T+1, no mem_we, memory unchanged.
4. LW addr 0x00001000 and SW addr 0xFFFFFFFC -> resp_error=10 at T+1, no mem_we; LW 0x00000FFC succeeds.
5. Backpressure: hold resp_ready=0 for 3 cycles after a load response while req_valid=1 with a different request -> resp_valid, resp_rdata and resp_error stay stable, req_ready=0, and the second request is accepted only in the cycle after the response handshake.
6. Assert resetn=0 during the READ state of an SB -> mem_we stays 0, resp_valid=0, req_ready=1 after release, target word unchanged; a subsequent LW returns the original value.
